thresholding_cfg_loader: RTL and testbench
==========================================

Name: thresholding_cfg_loader

Overview:
- Upstream configuration stage for the thresholding AXI adapter.
- Consumes a stream of threshold values, channel-major, and drives the adapter's AXI-Lite write channel: one single-beat write per threshold, covering all C channels × (2^N−1) thresholds.
- Runs once per start pulse and reports busy, done and response errors.
- Lets a DMA-fed threshold image program the core without a CPU.

Parameters:
- N, 4, output precision of the thresholding core; thresholds per channel = 2^N−1.
- M, 8, threshold precision; valid bits of each stream word.
- C, 1, channel count.
- localparam C_BITS = C<2 ? 1 : $clog2(C); A_BITS = $clog2(C)+N (matches adapter AWADDR width).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a load; ignored unless idle
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last B response
- err  out  1  sticky; set on any nonzero BRESP; cleared by accepted start
- s_axis_tvalid  in  1  threshold stream valid
- s_axis_tready  out  1  threshold stream ready
- s_axis_tdata  in  ((M+7)/8)*8  threshold, bits [M-1:0] used
- m_axilite_AWVALID  out  1 / AWREADY  in  1 / AWADDR  out  A_BITS
- m_axilite_WVALID  out  1 / WREADY  in  1 / WDATA  out  32 / WSTRB  out  4
- m_axilite_BVALID  in  1 / BREADY  out  1 / BRESP  in  2

Behaviour:
- Reset values:
  - State IDLE; busy=0, done=0, err=0, s_axis_tready=0.
  - AWVALID=0, WVALID=0, BREADY=0; counters 0.
- FSM states and transitions:
  - IDLE: start → FETCH; clear err and counters; busy=1.
  - FETCH: s_axis_tready=1. On handshake, capture tdata[M-1:0] → WRITE.
  - WRITE: AWVALID and WVALID both asserted from the first WRITE cycle. Each channel is tracked independently (AW_done, W_done flags). A VALID drops the cycle after its own handshake and never drops before it. When both are done (including both in the same cycle) → RESP.
  - RESP: BREADY=1. On BVALID: err |= (BRESP!=0); advance counters. Then → DONE if last, else → FETCH.
  - DONE: done=1 for exactly one cycle, busy=0 → IDLE.
- Address and data:
  - AWADDR = {cnl[C_BITS-1:0], idx[N-1:0]}. For C==1, cnl contributes no bits; AWADDR = idx.
  - WDATA = zero-extended threshold, bits [31:M]=0. WSTRB=4'hF.
- Counters:
  - idx runs 0..2^N−2, wraps to 0 and increments cnl.
  - Last = (idx==2^N−2 && cnl==C−1). Total writes per load = C·(2^N−1).
- Handshakes and ordering:
  - Exactly one write outstanding at a time. A stream word is never accepted while a write or response is pending.
  - AWADDR and WDATA are stable while their VALID is high.
  - BVALID outside RESP is ignored; BREADY=0 there.
- Throughput: minimum 3 cycles per threshold (FETCH, WRITE, RESP) with all peers always ready.
- Boundary conditions:
  - start while busy: ignored.
  - start in the same cycle as done: ignored; a new start is needed in IDLE.
  - Stream stall: remain in FETCH indefinitely, no timeout.
  - err stays sticky through the remainder of the load; the load continues on error.
  - Reset mid-operation: all VALIDs drop the next cycle and the state returns to IDLE. The downstream must be reset with it; no attempt to complete the transaction.
  - Extra stream words after the last write are not consumed.

Decomposition:
- Package thresholding_pkg:
  - FSM state enum (IDLE, FETCH, WRITE, RESP, DONE).
  - AXI-Lite response constant RESP_OKAY=2'b00.
- No sub-module; a single flat module. Counters and FSM live in one always_ff.

Test Plan:
- N=2, M=8, C=3, all ready, stream 1..9 → 9 writes.
  - AWADDR sequence 0,1,2,4,5,6,8,9,10; WDATA 1..9; WSTRB=F.
  - done after the 9th B; busy high throughout; 27+2 cycles start→done.
- AWREADY delayed 3 cycles, WREADY immediate → WVALID drops after 1 cycle, AWVALID held 3 cycles with stable AWADDR; RESP entered only after both handshakes.
- BRESP=2'b10 on write 4 → err=1 stays set through done. The next start clears err; a clean reload leaves err=0.
- s_axis_tvalid deasserted for 10 cycles mid-load → no AW/W activity during the gap; resumes with the correct idx/cnl.
- rst asserted while in WRITE → next cycle AWVALID=WVALID=0, busy=0. A new start restarts from AWADDR=0.
- Loader connected to the thresholding AXI adapter, C=2, N=2, followed by an input stream → outputs match a reference threshold comparison for all programmed thresholds.

Source files
------------

// File: rtl/thresholding_pkg.sv
// Shared types for the thresholding configuration loader.
//   state_t    : loader FSM states
//   RESP_OKAY  : AXI-Lite OKAY response code
package thresholding_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WRITE = 3'd2,
        RESP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/thresholding_cfg_loader.sv
// Threshold configuration loader.
// Pulls threshold words (channel-major) from an AXI-Stream source and writes
// each one, as a single-beat AXI-Lite write, into the thresholding adapter's
// register space. One load covers C channels x (2^N-1) thresholds.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle pulse, begins a load when idle
//   busy, done, err     status: load running / end pulse / sticky BRESP error
//   s_axis_*            threshold stream (tdata[M-1:0] used)
//   m_axilite_AW*/W*/B* AXI-Lite write channel towards the adapter
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start
// FETCH | tready high, waiting for the next threshold word
// WRITE | AWVALID/WVALID up, each dropped after its own handshake
// RESP  | BREADY high, waiting for the write response
// DONE  | one-cycle done pulse, back to IDLE
module thresholding_cfg_loader
    import thresholding_pkg::*;
#(
    parameter  int N      = 4,
    parameter  int M      = 8,
    parameter  int C      = 1,
    localparam int C_BITS = (C < 2) ? 1 : $clog2(C),
    localparam int A_BITS = $clog2(C) + N,
    localparam int TD_W   = ((M + 7) / 8) * 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [TD_W-1:0]   s_axis_tdata,
    output logic              m_axilite_AWVALID,
    input  logic              m_axilite_AWREADY,
    output logic [A_BITS-1:0] m_axilite_AWADDR,
    output logic              m_axilite_WVALID,
    input  logic              m_axilite_WREADY,
    output logic [31:0]       m_axilite_WDATA,
    output logic [3:0]        m_axilite_WSTRB,
    input  logic              m_axilite_BVALID,
    output logic              m_axilite_BREADY,
    input  logic [1:0]        m_axilite_BRESP
);

    localparam logic [N-1:0]      IDX_LAST = N'((1 << N) - 2);
    localparam logic [C_BITS-1:0] CNL_LAST = C_BITS'(C - 1);

    state_t            state;
    logic [N-1:0]      idx;
    logic [C_BITS-1:0] cnl;
    logic [M-1:0]      thr;

    logic aw_fin;
    logic w_fin;
    logic last;

    // A channel counts as finished once its VALID is already down or it is
    // completing its handshake this cycle, so same-cycle completion works.
    assign aw_fin = !m_axilite_AWVALID || m_axilite_AWREADY;
    assign w_fin  = !m_axilite_WVALID  || m_axilite_WREADY;
    assign last   = (idx == IDX_LAST) && (cnl == CNL_LAST);

    // Address and data come straight from registers that only change outside
    // WRITE, so they are stable while their VALID is high.
    generate
        if (C < 2) begin : g_addr_single
            assign m_axilite_AWADDR = idx;
        end else begin : g_addr_multi
            assign m_axilite_AWADDR = {cnl, idx};
        end
    endgenerate

    assign m_axilite_WDATA = 32'(thr);
    assign m_axilite_WSTRB = 4'hF;

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            busy              <= 1'b0;
            done              <= 1'b0;
            err               <= 1'b0;
            s_axis_tready     <= 1'b0;
            m_axilite_AWVALID <= 1'b0;
            m_axilite_WVALID  <= 1'b0;
            m_axilite_BREADY  <= 1'b0;
            idx               <= '0;
            cnl               <= '0;
            thr               <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= FETCH;
                        busy          <= 1'b1;
                        err           <= 1'b0;
                        idx           <= '0;
                        cnl           <= '0;
                        s_axis_tready <= 1'b1;
                    end
                end

                FETCH: begin
                    if (s_axis_tvalid) begin
                        thr               <= s_axis_tdata[M-1:0];
                        s_axis_tready     <= 1'b0;
                        m_axilite_AWVALID <= 1'b1;
                        m_axilite_WVALID  <= 1'b1;
                        state             <= WRITE;
                    end
                end

                WRITE: begin
                    if (m_axilite_AWVALID && m_axilite_AWREADY) begin
                        m_axilite_AWVALID <= 1'b0;
                    end
                    if (m_axilite_WVALID && m_axilite_WREADY) begin
                        m_axilite_WVALID <= 1'b0;
                    end
                    if (aw_fin && w_fin) begin
                        m_axilite_BREADY <= 1'b1;
                        state            <= RESP;
                    end
                end

                RESP: begin
                    if (m_axilite_BVALID) begin
                        m_axilite_BREADY <= 1'b0;
                        if (m_axilite_BRESP != RESP_OKAY) begin
                            err <= 1'b1;
                        end
                        if (last) begin
                            idx   <= '0;
                            cnl   <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            if (idx == IDX_LAST) begin
                                idx <= '0;
                                cnl <= cnl + 1'b1;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                            s_axis_tready <= 1'b1;
                            state         <= FETCH;
                        end
                    end
                end

                DONE: begin
                    // start is deliberately not looked at here; a new load
                    // needs a fresh pulse once back in IDLE.
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_thresholding_cfg_loader.sv
module tb_thresholding_cfg_loader;

    localparam int N      = 2;
    localparam int M      = 8;
    localparam int C      = 3;
    localparam int A_BITS = $clog2(C) + N;
    localparam int TD_W   = ((M + 7) / 8) * 8;
    localparam int PER_CH = (1 << N) - 1;
    localparam int TOTAL  = C * PER_CH;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              busy;
    logic              done;
    logic              err;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic [TD_W-1:0]   s_axis_tdata;
    logic              awvalid;
    logic              awready;
    logic [A_BITS-1:0] awaddr;
    logic              wvalid;
    logic              wready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;

    thresholding_cfg_loader #(.N(N), .M(M), .C(C)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .busy              (busy),
        .done              (done),
        .err               (err),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tready     (s_axis_tready),
        .s_axis_tdata      (s_axis_tdata),
        .m_axilite_AWVALID (awvalid),
        .m_axilite_AWREADY (awready),
        .m_axilite_AWADDR  (awaddr),
        .m_axilite_WVALID  (wvalid),
        .m_axilite_WREADY  (wready),
        .m_axilite_WDATA   (wdata),
        .m_axilite_WSTRB   (wstrb),
        .m_axilite_BVALID  (bvalid),
        .m_axilite_BREADY  (bready),
        .m_axilite_BRESP   (bresp)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]        src_q[$];
    logic [A_BITS-1:0] exp_addr_q[$];
    logic [31:0]       exp_data_q[$];

    int aw_delay  = 0;
    int w_delay   = 0;
    int aw_wait   = 0;
    int w_wait    = 0;
    int aw_len    = 0;
    int w_len     = 0;
    int ld_k      = 0;
    int b_num     = 0;
    int err_write = 0;
    bit stall     = 1'b0;
    bit b_noise   = 1'b0;
    bit aw_seen   = 1'b0;
    bit w_seen    = 1'b0;
    logic [A_BITS-1:0] aw_prev;
    logic [31:0]       w_prev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference address for the k-th threshold of a load: channel-major,
    // channel in the upper bits, threshold index in the low N bits.
    function automatic logic [A_BITS-1:0] model_addr(input int k);
        int ch;
        int ix;
        ch = k / PER_CH;
        ix = k % PER_CH;
        return A_BITS'((ch << N) | ix);
    endfunction

    // Stream source and AXI-Lite slave, driven on the falling edge.
    always @(negedge clk) begin
        if (!stall && src_q.size() > 0) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = src_q[0];
        end else begin
            s_axis_tvalid = 1'b0;
            s_axis_tdata  = '0;
        end
        awready = awvalid && (aw_wait >= aw_delay);
        wready  = wvalid && (w_wait >= w_delay);
        if (bready) begin
            bvalid = 1'b1;
            bresp  = (b_num + 1 == err_write) ? 2'b10 : 2'b00;
        end else if (b_noise) begin
            bvalid = 1'b1;
            bresp  = 2'b11;
        end else begin
            bvalid = 1'b0;
            bresp  = 2'b00;
        end
    end

    // Monitor: everything is stable here, and a valid/ready pair seen now
    // completes at the next rising edge.
    always begin
        @(negedge clk);
        #1;
        if (rst) begin
            aw_wait = 0;
            w_wait  = 0;
            aw_len  = 0;
            w_len   = 0;
            aw_seen = 1'b0;
            w_seen  = 1'b0;
        end else begin
            if (s_axis_tready) begin
                check("fetch_bus_quiet", 32'({awvalid, wvalid, bready}), 32'd0);
            end
            if (s_axis_tvalid && s_axis_tready) begin
                exp_addr_q.push_back(model_addr(ld_k));
                exp_data_q.push_back(32'(src_q[0]));
                void'(src_q.pop_front());
                ld_k++;
            end
            if (bready) begin
                check("resp_after_aw_w", 32'({awvalid, wvalid}), 32'd0);
            end
            if (awvalid) begin
                aw_len++;
                if (aw_seen) check("awaddr_stable", 32'(awaddr), 32'(aw_prev));
                aw_prev = awaddr;
                aw_seen = 1'b1;
                if (awready) begin
                    check("aw_expected", 32'(exp_addr_q.size() > 0), 32'd1);
                    if (exp_addr_q.size() > 0) begin
                        check("awaddr", 32'(awaddr), 32'(exp_addr_q.pop_front()));
                    end
                    check("aw_valid_len", aw_len, aw_delay + 1);
                    aw_len  = 0;
                    aw_wait = 0;
                    aw_seen = 1'b0;
                end else begin
                    aw_wait++;
                end
            end
            if (wvalid) begin
                w_len++;
                if (w_seen) check("wdata_stable", wdata, w_prev);
                w_prev = wdata;
                w_seen = 1'b1;
                if (wready) begin
                    check("w_expected", 32'(exp_data_q.size() > 0), 32'd1);
                    if (exp_data_q.size() > 0) begin
                        check("wdata", wdata, exp_data_q.pop_front());
                    end
                    check("wstrb", 32'(wstrb), 32'hF);
                    check("w_valid_len", w_len, w_delay + 1);
                    w_len   = 0;
                    w_wait  = 0;
                    w_seen  = 1'b0;
                end else begin
                    w_wait++;
                end
            end
            if (bready && bvalid) b_num++;
        end
    end

    // One full load of TOTAL words (base+1 .. base+TOTAL). Called and
    // returning just after a rising edge.
    task automatic run_load(input int base, input int exp_cyc, input bit mid_start,
                            input bit start_on_done, input int stall_at,
                            input logic exp_err, input bit extra);
        int cyc;
        int gap;
        bit stalled;
        for (int v = 1; v <= TOTAL; v++) src_q.push_back(8'(base + v));
        if (extra) src_q.push_back(8'h55);
        ld_k    = 0;
        b_num   = 0;
        stalled = 1'b0;
        gap     = 0;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 2;
        check("err_cleared_on_start", 32'(err), 32'd0);
        while (!done && cyc < 2000) begin
            check("busy_during_load", 32'(busy), 32'd1);
            if (err_write > 0 && b_num >= err_write) begin
                check("err_sticky", 32'(err), 32'd1);
            end
            if (mid_start && cyc == 10) start = 1'b1;
            if (mid_start && cyc == 11) start = 1'b0;
            if (stall_at > 0 && !stalled && ld_k >= stall_at) begin
                stall   = 1'b1;
                stalled = 1'b1;
            end
            if (stall && s_axis_tready) begin
                check("gap_no_aw_w", 32'({awvalid, wvalid}), 32'd0);
                gap++;
                if (gap == 10) stall = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        stall = 1'b0;
        check("done_seen", 32'(done), 32'd1);
        if (exp_cyc > 0) check("start_to_done_cycles", cyc, exp_cyc);
        check("busy_low_at_done", 32'(busy), 32'd0);
        check("err_at_done", 32'(err), 32'(exp_err));
        if (start_on_done) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("done_one_cycle", 32'(done), 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("idle_after_load", 32'({busy, s_axis_tready}), 32'd0);
        check("b_count", b_num, TOTAL);
        check("writes_outstanding", exp_addr_q.size() + exp_data_q.size(), 0);
        check("stream_leftover", src_q.size(), extra ? 1 : 0);
        src_q.delete();
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        bresp   = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'({busy, done, err, s_axis_tready, awvalid, wvalid, bready}), 32'd0);
        check("reset_awaddr", 32'(awaddr), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // All peers ready, stray BVALID outside RESP, start while busy,
        // start on the done cycle, one surplus stream word.
        b_noise = 1'b1;
        run_load(0, 29, 1'b1, 1'b1, 0, 1'b0, 1'b1);
        b_noise = 1'b0;

        // AWREADY held off 3 cycles, WREADY immediate.
        aw_delay = 3;
        run_load(8'h10, 56, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        aw_delay = 0;

        // Error response on the 4th write, then a clean reload.
        err_write = 4;
        run_load(8'hA0, 29, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        err_write = 0;
        run_load(8'h30, 29, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        // Stream stall of 10 cycles after the 4th word.
        run_load(8'h40, 0, 1'b0, 1'b0, 4, 1'b0, 1'b0);

        // Reset while in WRITE, then a fresh load from address 0.
        aw_delay = 3;
        for (int v = 1; v <= 3; v++) src_q.push_back(8'(8'h70 + v));
        ld_k  = 0;
        b_num = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 20 && !awvalid; i++) begin
            @(posedge clk); #1;
        end
        check("write_reached", 32'(awvalid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("reset_mid_write", 32'({awvalid, wvalid, bready, busy}), 32'd0);
        rst = 1'b0;
        src_q.delete();
        exp_addr_q.delete();
        exp_data_q.delete();
        aw_delay = 0;
        @(posedge clk); #1;
        run_load(8'h60, 29, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
